// File: rtl/mbist_response_analyzer.sv
// mbist_response_analyzer
// Read-side checker for the March BIST generator driving the 256x4 SRAM.
// Snoops the generator command bus, aligns each read's expected value with
// the SRAM read data READ_LAT cycles later, and accumulates a verdict.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | waiting for cen; nothing compared
// RUN    | generator active; reads are issued into the alignment pipe
// DRAIN  | generator finished; in-flight reads still being compared
// DONE   | verdict valid (done=1, pass=~fail); held until reset
module mbist_response_analyzer #(
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 4,
    parameter int READ_LAT = 1,
    parameter int ECNT_W   = 8,
    parameter int RCNT_W   = 11
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_cen,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_cout,
    input  logic [DATA_W-1:0] i_rdata,
    output logic              o_fail,
    output logic [ECNT_W-1:0] o_err_cnt,
    output logic [ADDR_W-1:0] o_fail_addr,
    output logic [DATA_W-1:0] o_fail_mask,
    output logic [RCNT_W-1:0] o_rd_cnt,
    output logic              o_done,
    output logic              o_pass
);

    // Drain timer just needs to hold READ_LAT.
    localparam int DCNT_W = (READ_LAT < 2) ? 1 : $clog2(READ_LAT + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [DCNT_W-1:0]   r_dcnt;
    logic [DCNT_W-1:0]   w_dcnt_nxt;
    logic                w_to_run;
    logic                w_rd_req;

    logic                r_pipe_vld  [READ_LAT];
    logic [ADDR_W-1:0]   r_pipe_addr [READ_LAT];
    logic [DATA_W-1:0]   r_pipe_exp  [READ_LAT];

    logic                w_tail_vld;
    logic [DATA_W-1:0]   w_mism;
    logic                w_err;

    logic                r_fail;
    logic [ECNT_W-1:0]   r_err_cnt;
    logic [ADDR_W-1:0]   r_fail_addr;
    logic [DATA_W-1:0]   r_fail_mask;
    logic [RCNT_W-1:0]   r_rd_cnt;

    // State and drain-timer registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
            r_dcnt  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_dcnt  <= w_dcnt_nxt;
        end
    end

    // Next-state logic, drain timer and read strobe.
    always_comb begin
        w_state_nxt = r_state;
        w_dcnt_nxt  = r_dcnt;
        w_to_run    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_cen) begin
                    w_state_nxt = ST_RUN;
                    w_to_run    = 1'b1;
                end
            end
            ST_RUN: begin
                if (i_cen && i_cout) begin
                    w_state_nxt = ST_DRAIN;
                    w_dcnt_nxt  = DCNT_W'(READ_LAT);
                end
            end
            ST_DRAIN: begin
                // Terminal count at 1: DONE lands READ_LAT edges after cout.
                if (r_dcnt == DCNT_W'(1)) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_dcnt_nxt = r_dcnt - 1'b1;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_DONE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
        // The generator parks with we=0 once finished, so cout masks reads.
        w_rd_req = i_cen & ~i_we & ~i_cout & ((r_state == ST_RUN) | w_to_run);
    end

    // Alignment pipe: shifts every cycle so SRAM latency stays wall-clock.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < READ_LAT; i++) begin
                r_pipe_vld[i]  <= 1'b0;
                r_pipe_addr[i] <= '0;
                r_pipe_exp[i]  <= '0;
            end
        end else begin
            r_pipe_vld[0]  <= w_rd_req;
            r_pipe_addr[0] <= i_addr;
            r_pipe_exp[0]  <= i_data;
            for (int i = 1; i < READ_LAT; i++) begin
                r_pipe_vld[i]  <= r_pipe_vld[i-1];
                r_pipe_addr[i] <= r_pipe_addr[i-1];
                r_pipe_exp[i]  <= r_pipe_exp[i-1];
            end
        end
    end

    assign w_tail_vld = r_pipe_vld[READ_LAT-1];
    assign w_mism     = i_rdata ^ r_pipe_exp[READ_LAT-1];
    assign w_err      = w_tail_vld & (|w_mism);

    // Result accumulation; first-failure capture is frozen once fail is set.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_fail      <= 1'b0;
            r_err_cnt   <= '0;
            r_fail_addr <= '0;
            r_fail_mask <= '0;
            r_rd_cnt    <= '0;
        end else if (w_tail_vld) begin
            if (!(&r_rd_cnt)) begin
                r_rd_cnt <= r_rd_cnt + 1'b1;
            end
            if (w_err) begin
                r_fail <= 1'b1;
                if (!(&r_err_cnt)) begin
                    r_err_cnt <= r_err_cnt + 1'b1;
                end
                if (!r_fail) begin
                    r_fail_addr <= r_pipe_addr[READ_LAT-1];
                    r_fail_mask <= w_mism;
                end
            end
        end
    end

    assign o_fail      = r_fail;
    assign o_err_cnt   = r_err_cnt;
    assign o_fail_addr = r_fail_addr;
    assign o_fail_mask = r_fail_mask;
    assign o_rd_cnt    = r_rd_cnt;
    assign o_done      = (r_state == ST_DONE);
    assign o_pass      = (r_state == ST_DONE) & ~r_fail;

endmodule

// File: tb/tb_mbist_response_analyzer.sv
// Bench for mbist_response_analyzer: one instance at READ_LAT=1 and one at
// READ_LAT=2 share the generator stimulus; each has its own SRAM output path.
module tb_mbist_response_analyzer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cen = 1'b0;
    logic       we = 1'b0;
    logic [7:0] addr = '0;
    logic [3:0] data = '0;
    logic       cout = 1'b0;
    logic [3:0] rdata1;
    logic [3:0] rdata2;

    logic        fail_o  [2];
    logic [7:0]  err_o   [2];
    logic [7:0]  faddr_o [2];
    logic [3:0]  fmask_o [2];
    logic [10:0] rd_o    [2];
    logic        done_o  [2];
    logic        pass_o  [2];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mbist_response_analyzer #(.READ_LAT(1)) u_dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_cen(cen), .i_we(we), .i_addr(addr),
        .i_data(data), .i_cout(cout), .i_rdata(rdata1),
        .o_fail(fail_o[0]), .o_err_cnt(err_o[0]), .o_fail_addr(faddr_o[0]),
        .o_fail_mask(fmask_o[0]), .o_rd_cnt(rd_o[0]), .o_done(done_o[0]),
        .o_pass(pass_o[0])
    );

    mbist_response_analyzer #(.READ_LAT(2)) u_dut2 (
        .i_clk(clk), .i_rst_n(rst_n), .i_cen(cen), .i_we(we), .i_addr(addr),
        .i_data(data), .i_cout(cout), .i_rdata(rdata2),
        .o_fail(fail_o[1]), .o_err_cnt(err_o[1]), .o_fail_addr(faddr_o[1]),
        .o_fail_mask(fmask_o[1]), .o_rd_cnt(rd_o[1]), .o_done(done_o[1]),
        .o_pass(pass_o[1])
    );

    // SRAM model: 0 none, 1 bit2 stuck-at-0 @0x3C, 2 rdata forced 1111,
    // 3 bit0 flipped on reads of 0x55.
    int         fault_mode = 0;
    logic [3:0] mem [256];
    logic [3:0] q1 = '0;
    logic [3:0] q2a = '0;
    logic [3:0] q2 = '0;

    initial for (int i = 0; i < 256; i++) mem[i] = 4'h0;

    function automatic logic [3:0] sram_fault(input logic [7:0] a, input logic [3:0] v);
        if (fault_mode == 1 && a == 8'h3C) return v & 4'b1011;
        if (fault_mode == 3 && a == 8'h55) return v ^ 4'b0001;
        return v;
    endfunction

    always @(posedge clk) begin
        if (cen) begin
            if (we) mem[addr] <= data;
            else begin
                q1  <= sram_fault(addr, mem[addr]);
                q2a <= sram_fault(addr, mem[addr]);
            end
        end
        q2 <= q2a;
    end

    assign rdata1 = (fault_mode == 2) ? 4'hF : q1;
    assign rdata2 = (fault_mode == 2) ? 4'hF : q2;

    // Reference model: every accepted read is logged with its issue cycle;
    // a read issued at cycle c is judged at cycle c+L against that DUT's rdata.
    int         cyc = 0;
    int         rec_t [2048];
    logic [7:0] rec_a [2048];
    logic [3:0] rec_e [2048];
    int         wp = 0;
    int         rp [2] = '{0, 0};
    bit         started = 0;
    bit         fin = 0;
    int         fin_at = 0;
    bit         m_fail  [2] = '{0, 0};
    int         m_err   [2] = '{0, 0};
    logic [7:0] m_faddr [2] = '{8'h0, 8'h0};
    logic [3:0] m_fmask [2] = '{4'h0, 4'h0};
    int         m_rd    [2] = '{0, 0};
    bit         m_done  [2] = '{0, 0};

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp = 0; started = 0; fin = 0; fin_at = 0;
            for (int d = 0; d < 2; d++) begin
                rp[d] = 0; m_fail[d] = 0; m_err[d] = 0; m_faddr[d] = 0;
                m_fmask[d] = 0; m_rd[d] = 0; m_done[d] = 0;
            end
        end else begin
            cyc++;
            for (int d = 0; d < 2; d++) begin
                logic [3:0] v, mism;
                if (rp[d] != wp && rec_t[rp[d] & 2047] + d + 1 == cyc) begin
                    v    = (d == 0) ? rdata1 : rdata2;
                    mism = v ^ rec_e[rp[d] & 2047];
                    if (m_rd[d] < 2047) m_rd[d]++;
                    if (mism != 0) begin
                        if (!m_fail[d]) begin
                            m_faddr[d] = rec_a[rp[d] & 2047];
                            m_fmask[d] = mism;
                        end
                        m_fail[d] = 1;
                        if (m_err[d] < 255) m_err[d]++;
                    end
                    rp[d]++;
                end
                if (fin && cyc >= fin_at + d + 1) m_done[d] = 1;
            end
            if ((started || cen) && !fin && cen && !we && !cout) begin
                rec_t[wp & 2047] = cyc;
                rec_a[wp & 2047] = addr;
                rec_e[wp & 2047] = data;
                wp++;
            end
            if (started && !fin && cen && cout) begin
                fin = 1;
                fin_at = cyc;
            end
            if (cen) started = 1;
        end
    end

    // Cycle-by-cycle comparison of both DUTs against the model.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int d = 0; d < 2; d++) begin
                n_tests++;
                if (fail_o[d] !== m_fail[d] || err_o[d] !== 8'(m_err[d]) ||
                    faddr_o[d] !== m_faddr[d] || fmask_o[d] !== m_fmask[d] ||
                    rd_o[d] !== 11'(m_rd[d]) || done_o[d] !== m_done[d] ||
                    pass_o[d] !== (m_done[d] & ~m_fail[d])) begin
                    n_fail++;
                    $display("FAIL cycle lat%0d cyc %0d: got f=%0b e=%0d a=%h m=%h r=%0d d=%0b p=%0b expected f=%0b e=%0d a=%h m=%h r=%0d d=%0b p=%0b",
                             d + 1, cyc, fail_o[d], err_o[d], faddr_o[d], fmask_o[d],
                             rd_o[d], done_o[d], pass_o[d], m_fail[d], m_err[d],
                             m_faddr[d], m_fmask[d], m_rd[d], m_done[d],
                             m_done[d] & ~m_fail[d]);
                end
            end
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_final(input string sc, input int efail, input int eerr,
                             input int eaddr, input int emask, input int erd);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("%s lat%0d done", sc, d + 1), int'(done_o[d]), 1);
            chk($sformatf("%s lat%0d pass", sc, d + 1), int'(pass_o[d]), 1 - efail);
            chk($sformatf("%s lat%0d fail", sc, d + 1), int'(fail_o[d]), efail);
            chk($sformatf("%s lat%0d err_cnt", sc, d + 1), int'(err_o[d]), eerr);
            chk($sformatf("%s lat%0d fail_addr", sc, d + 1), int'(faddr_o[d]), eaddr);
            chk($sformatf("%s lat%0d fail_mask", sc, d + 1), int'(fmask_o[d]), emask);
            chk($sformatf("%s lat%0d rd_cnt", sc, d + 1), int'(rd_o[d]), erd);
        end
    endtask

    task automatic chk_zero(input string sc);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("%s lat%0d outputs", sc, d + 1),
                int'({fail_o[d], err_o[d], faddr_o[d], fmask_o[d], rd_o[d],
                      done_o[d], pass_o[d]}), 0);
        end
    endtask

    // Called at a negedge; leaves the bench at a negedge.
    task automatic do_reset();
        cen = 0; we = 0; cout = 0;
        #2 rst_n = 1'b0;
        #1 chk_zero("reset");
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic op(input logic w, input logic [7:0] a, input logic [3:0] d);
        cen = 1; we = w; addr = a; data = d; cout = 0;
        @(negedge clk);
    endtask

    // March: up w0; up(r0,w1); up(r1,w0); down(r0,w1); down(r1,w0).
    task automatic run_march(input int stall_stage, input int abort_stage);
        for (int i = 0; i < 256; i++) op(1'b1, 8'(i), 4'h0);
        for (int s = 1; s <= 4; s++) begin
            logic [3:0] rexp;
            rexp = (s == 1 || s == 3) ? 4'h0 : 4'hF;
            for (int i = 0; i < 256; i++) begin
                logic [7:0] a;
                a = (s <= 2) ? 8'(i) : 8'(255 - i);
                if (s == abort_stage && i == 128) return;
                op(1'b0, a, rexp);
                if (s == stall_stage && i == 100) begin
                    cen = 0; we = 0;
                    repeat (5) @(negedge clk);
                end
                op(1'b1, a, ~rexp);
            end
        end
    endtask

    task automatic finish_run();
        cen = 1; we = 0; cout = 1;
        @(negedge clk);
        for (int i = 0; i < 12; i++) begin
            if (done_o[0] && done_o[1]) break;
            @(negedge clk);
        end
    endtask

    initial begin
        @(negedge clk);
        chk_zero("power-on reset");
        #2 rst_n = 1'b1;
        @(negedge clk);

        // Ideal SRAM.
        fault_mode = 0;
        run_march(-1, -1);
        finish_run();
        chk_final("ideal", 0, 0, 0, 0, 1024);

        // Bit 2 stuck-at-0 at 0x3C: only the two expect-1111 reads miss.
        do_reset();
        fault_mode = 1;
        run_march(-1, -1);
        finish_run();
        chk_final("stuck", 1, 2, 8'h3C, 4'b0100, 1024);

        // rdata forced to 1111: 512 misses, counter saturates.
        do_reset();
        fault_mode = 2;
        run_march(-1, -1);
        finish_run();
        chk_final("forced", 1, 255, 8'h00, 4'hF, 1024);

        // 5-cycle cen stall in stage 2 with a read in flight.
        do_reset();
        fault_mode = 0;
        run_march(2, -1);
        finish_run();
        chk_final("stall", 0, 0, 0, 0, 1024);

        // Fault, abort midway through stage 3, reset, clean rerun.
        do_reset();
        fault_mode = 1;
        run_march(-1, 3);
        chk("abort lat1 fail before reset", int'(fail_o[0]), 1);
        chk("abort lat2 fail before reset", int'(fail_o[1]), 1);
        do_reset();
        fault_mode = 0;
        run_march(-1, -1);
        finish_run();
        chk_final("rerun", 0, 0, 0, 0, 1024);

        // Last read corrupted and still in flight when cout rises.
        do_reset();
        fault_mode = 3;
        op(1'b1, 8'h55, 4'hA);
        op(1'b1, 8'h10, 4'h5);
        op(1'b0, 8'h10, 4'h5);
        op(1'b0, 8'h55, 4'hA);
        cen = 1; we = 0; cout = 1;
        @(negedge clk);
        chk("tail lat1 done +0", int'(done_o[0]), 0);
        chk("tail lat2 done +0", int'(done_o[1]), 0);
        chk("tail lat1 err +0", int'(err_o[0]), 1);
        @(negedge clk);
        chk("tail lat1 done +1", int'(done_o[0]), 1);
        chk("tail lat2 done +1", int'(done_o[1]), 0);
        chk("tail lat2 err +1", int'(err_o[1]), 1);
        @(negedge clk);
        chk_final("tail", 1, 1, 8'h55, 4'b0001, 2);

        do_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mbist_response_analyzer.md
Name: mbist_response_analyzer

Overview:
Read-side checker for the March BIST pattern generator that drives the 256x4 SRAM. It snoops the generator's SRAM command bus (we, addr, data, cout) alongside the SRAM read data. For each read operation it compares the returned data against the expected value after a fixed read latency. It reports a sticky fail flag, a saturating error count, first-failure address and bit mask, a read count, and a final done/pass verdict to the test controller.

Parameters:
ADDR_W, 8, SRAM address width (must match generator addr)
DATA_W, 4, SRAM data width
READ_LAT, 1, SRAM read latency in clk cycles (>=1)
ECNT_W, 8, error counter width (saturating)
RCNT_W, 11, read counter width (full March run = 1024 reads)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-low reset (0 = reset)
cen  in  1  BIST enable, same signal driving the generator
we  in  1  generator write enable (1 = write, 0 = read)
addr  in  ADDR_W  generator SRAM address
data  in  DATA_W  generator data; during a read it carries the expected value
cout  in  1  generator completion flag
rdata  in  DATA_W  SRAM read data, valid READ_LAT cycles after the read is issued
fail  out  1  sticky: at least one mismatch seen
err_cnt  out  ECNT_W  number of mismatching reads, saturates at all-ones
fail_addr  out  ADDR_W  address of the first mismatching read
fail_mask  out  DATA_W  rdata XOR expected for the first mismatching read
rd_cnt  out  RCNT_W  number of reads compared, saturating
done  out  1  analysis complete
pass  out  1  done & ~fail

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; all outputs 0; pipeline valid bits cleared.
- Read strobe rd_req = cen & ~we & ~cout & (state==RUN or a transition to RUN this cycle). cout gates reads because the generator drives we=0 in its finished stage.
- Alignment pipeline:
  - Depth READ_LAT of {valid, addr, expected=data}.
  - Stage 0 loads rd_req/addr/data at every edge.
  - Shifts every cycle regardless of cen, so SRAM latency is wall-clock.
- Compare at an edge where the tail entry is valid:
  - mism = rdata ^ tail.expected.
  - Read issued at edge k is compared at edge k+READ_LAT.
  - rd_cnt increments (saturating).
  - If mism != 0:
    - fail <= 1.
    - err_cnt increments (saturating).
    - If fail was 0 before this edge, capture fail_addr <= tail.addr and fail_mask <= mism.
    - Later failures never overwrite the capture.
- Outputs are registered and update one edge after the data is compared; no combinational path from rdata to outputs.
- FSM:
  - IDLE: -> RUN when cen=1.
  - RUN: -> DRAIN when cen=1 & cout=1.
  - DRAIN: a down-counter loaded with READ_LAT runs until the pipeline empties -> DONE. Reads already in flight are still compared.
  - DONE: done=1, pass=~fail. Holds until reset; all inputs ignored.
- cen=0 in RUN: no new reads enter; in-flight entries still compare; state holds.
- Reset mid-run: everything clears immediately; a new run starts on the next cen=1.
- Write operations (we=1) are never compared and never counted.

Test Plan:
- Ideal SRAM model, READ_LAT=1, full generator run -> done=1, pass=1, fail=0, err_cnt=0, rd_cnt=1024.
- Bit 2 stuck-at-0 at addr 0x3C -> fail=1, err_cnt=2 (the two expect-1111 reads), fail_addr=0x3C, fail_mask=4'b0100, pass=0 at done.
- rdata forced to 4'b1111 -> 512 expect-0000 mismatches; err_cnt=8'hFF (saturated), fail_addr=0x00, fail_mask=4'b1111, rd_cnt=1024.
- READ_LAT=2, SRAM model with 2-cycle latency, and cen deasserted for 5 cycles in stage 2 -> results identical to the ideal run; no spurious mismatches around the stall.
- Reset pulsed low for 1 cycle midway through stage 3 after an injected fault -> all outputs 0 immediately; a clean rerun ends with pass=1, err_cnt=0.
- cout rises while a read is in flight with READ_LAT=2 and the last read corrupted -> the read is still compared; done asserts 2 cycles after cout is sampled, with err_cnt=1.
